// File: rtl/dmem_lsu.sv
// dmem_lsu: data-memory load/store unit for the RV32I memory stage.
// Owns a word-organised RAM of DEPTH_WORDS x 32 bits and serves one
// request at a time over a valid/ready request/response handshake.
// Supports LB/LH/LW/LBU/LHU loads and SB/SH/SW stores (little-endian),
// with WAIT_STATES extra cycles between accept and the memory access.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid / req_ready  request handshake (ready only while idle)
//   req_we                 1 = store, 0 = load
//   req_funct3             RV32I funct3 selecting access size/extension
//   req_addr, req_wdata    byte address and store data
//   rsp_valid / rsp_ready  response handshake
//   rsp_rdata              extended load data (0 for stores and errors)
//   rsp_err                illegal funct3, out-of-range or misaligned
//
// Build option: define DMEM_LSU_MISALIGN_TRAP_EN to report misaligned
// halfword/word accesses as errors; otherwise the low address bits are
// truncated to the natural alignment and the access completes.
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             size_half, size_word;
  logic             funct_ok, in_range, misalign, acc_err;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word, wr_word, load_data;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic             do_write;

  // Access decode on the latched request
  always_comb begin
    size_half = (f3_q[1:0] == 2'b01);
    size_word = (f3_q[1:0] == 2'b10);
    case (f3_q)
      3'b000, 3'b001, 3'b010: funct_ok = 1'b1;
      3'b100, 3'b101:         funct_ok = !we_q;
      default:                funct_ok = 1'b0;
    endcase
    in_range = (addr_q[31:2] < 30'(DEPTH_WORDS));
    idx      = addr_q[IDX_W+1:2];
  end

  always_comb begin
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    misalign = (size_half && addr_q[0]) || (size_word && (addr_q[1:0] != 2'b00));
    lane     = addr_q[1:0];
`else
    // Misaligned addresses fall back to the naturally aligned lane
    misalign = 1'b0;
    lane     = size_word ? 2'b00 : (size_half ? {addr_q[1], 1'b0} : addr_q[1:0]);
`endif
    acc_err  = !funct_ok || !in_range || misalign;
  end

  // Read path and load extension
  always_comb begin
    rd_word  = mem[idx];
    sel_byte = rd_word[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = rd_word;
    endcase
  end

  // Store merge: untouched lanes keep their current contents
  always_comb begin
    wr_word = rd_word;
    case (f3_q[1:0])
      2'b00: wr_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (lane[1]) wr_word[31:16] = wdata_q[15:0];
        else         wr_word[15:0]  = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
    do_write = (state == BUSY) && (cnt == '0) && we_q && !acc_err;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = BUSY;
      end
      BUSY: if (cnt == '0) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt     <= 4'(WAIT_STATES);
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_rdata <= (acc_err || we_q) ? '0 : load_data;
            rsp_err   <= acc_err;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset; a reset cycle suppresses any pending write
  always_ff @(posedge clk) begin
    if (rst_n && do_write) mem[idx] <= wr_word;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [31:0] ref_mem [2][DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int exp_lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Byte-level reference: sizes, alignment and extension from the ISA rules
  task automatic model(input int d, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int unsigned size, base, w, pos;
    bit legal;
    logic [31:0] word, v;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    base = a;
    if (a % size != 0) begin
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      legal = 1'b0;
`else
      base = a - (a % size);
`endif
    end
    w = a / 4;
    if (w >= DEPTH) legal = 1'b0;
    rd = '0;
    er = !legal;
    if (legal) begin
      word = ref_mem[d][w];
      v = '0;
      for (int k = 0; k < int'(size); k++) begin
        pos = (base % 4) + k;
        if (we) word[8*pos +: 8] = wd[8*k +: 8];
        else    v[8*k +: 8] = word[8*pos +: 8];
      end
      if (we) ref_mem[d][w] = word;
      else begin
        if (size == 1 && !f3[2] && v[7])  v[31:8]  = '1;
        if (size == 2 && !f3[2] && v[15]) v[31:16] = '1;
        rd = v;
      end
    end
  endtask

  task automatic issue(input int d, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int t;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    t = 0;
    while (req_ready[d] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    n_tests++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL accept_timeout dut%0d: req_ready=%b required 1", d, req_ready[d]);
    end
    @(posedge clk);
    #1;
    // Garbage after the accept edge must be ignored
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_funct3[d] = 3'($urandom);
    req_addr[d] = $urandom; req_wdata[d] = $urandom;
    rsp_ready[d] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rsp(input int d, output int lat);
    @(negedge clk);
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    n_tests++;
    if (lat >= 100) begin
      n_fail++;
      $display("FAIL rsp_timeout dut%0d: rsp_valid=%b required 1", d, rsp_valid[d]);
    end
  endtask

  task automatic finish_rsp(input int d);
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_handshake dut%0d: req_ready=%b rsp_valid=%b required 1/0",
               d, req_ready[d], rsp_valid[d]);
    end
  endtask

  task automatic xact(input int d, input bit we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat,
                      output logic [31:0] erd, output logic eer);
    model(d, we, f3, a, wd, erd, eer);
    issue(d, we, f3, a, wd);
    wait_rsp(d, lat);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    finish_rsp(d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = '0;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 ||
          rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] rd, erd; logic er, eer; int lat;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < int'(DEPTH); i++) begin
        xact(d, 1'b1, 3'b010, 32'(4*i), $urandom, rd, er, lat, erd, eer);
        n_tests++;
        if (er !== 1'b0 || rd !== 32'h0) begin
          n_fail++;
          $display("FAIL fill dut%0d word %0d: err=%b rdata=%h required 0/0", d, i, er, rd);
        end
      end
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xact(0, 1'b1, 3'b010, 32'd16, 32'hABCDEF11, rd, er, lat, erd, eer);
    n_tests++;
    if (er !== 1'b0 || rd !== 32'h0 || lat != 1) begin
      n_fail++;
      $display("FAIL sw_16: err=%b rdata=%h lat=%0d required 0/0/1", er, rd, lat);
    end
    xact(0, 1'b0, 3'b010, 32'd16, 32'h0, rd, er, lat, erd, eer);
    n_tests++;
    if (er !== 1'b0 || rd !== 32'hABCDEF11 || lat != 1) begin
      n_fail++;
      $display("FAIL lw_16: err=%b rdata=%h lat=%0d required 0/abcdef11/1", er, rd, lat);
    end
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd, erd; logic er, eer; int lat;
    logic [2:0]  f3s  [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as   [5] = '{32'd16, 32'd17, 32'd17, 32'd18, 32'd18};
    logic [31:0] exps [5] = '{32'hABCD8011, 32'hFFFFFF80, 32'h00000080,
                              32'hFFFFABCD, 32'h0000ABCD};
    xact(0, 1'b1, 3'b000, 32'd17, 32'h5A5A5A80, rd, er, lat, erd, eer);
    for (int i = 0; i < 5; i++) begin
      xact(0, 1'b0, f3s[i], as[i], 32'h0, rd, er, lat, erd, eer);
      n_tests++;
      if (er !== 1'b0 || rd !== exps[i]) begin
        n_fail++;
        $display("FAIL merge_load f3=%0d addr=%0d: err=%b rdata=%h required 0/%h",
                 f3s[i], as[i], er, rd, exps[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, erd; logic er, eer; int lat;
    logic [31:0] want_rd; logic want_er;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    want_rd = 32'h0;        want_er = 1'b1;
`else
    want_rd = 32'hABCD8011; want_er = 1'b0;
`endif
    xact(0, 1'b0, 3'b010, 32'd18, 32'h0, rd, er, lat, erd, eer);
    n_tests++;
    if (er !== want_er || rd !== want_rd) begin
      n_fail++;
      $display("FAIL misalign_lw18: err=%b rdata=%h required %b/%h", er, rd, want_er, want_rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xact(0, 1'b0, 3'b010, 32'(4*DEPTH), 32'h0, rd, er, lat, erd, eer);
    n_tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_range: err=%b rdata=%h required 1/0", er, rd);
    end
    xact(0, 1'b0, 3'b011, 32'd16, 32'h0, rd, er, lat, erd, eer);
    n_tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_ld_f3: err=%b rdata=%h required 1/0", er, rd);
    end
    xact(0, 1'b1, 3'b100, 32'd16, 32'hDEADBEEF, rd, er, lat, erd, eer);
    n_tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_st_f3: err=%b rdata=%h required 1/0", er, rd);
    end
    xact(0, 1'b0, 3'b010, 32'd16, 32'h0, rd, er, lat, erd, eer);
    n_tests++;
    if (er !== 1'b0 || rd !== 32'hABCD8011) begin
      n_fail++;
      $display("FAIL err_st_nowrite: err=%b rdata=%h required 0/abcd8011", er, rd);
    end
  endtask

  task automatic test_wait_backpressure();
    logic [31:0] rd0, erd; logic eer; int lat;
    logic [31:0] a;
    a = 32'(4 * $urandom_range(0, DEPTH - 1));
    model(1, 1'b0, 3'b010, a, 32'h0, erd, eer);
    issue(1, 1'b0, 3'b010, a, 32'h0);
    rsp_ready[1] = 1'b0;
    wait_rsp(1, lat);
    rd0 = rsp_rdata[1];
    n_tests++;
    if (lat != 4 || rd0 !== erd || rsp_err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ws3_load: lat=%0d rdata=%h err=%b required 4/%h/0", lat, rd0, rsp_err[1], erd);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== rd0 || req_ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d: valid=%b rdata=%h ready=%b required 1/%h/0",
                 i, rsp_valid[1], rsp_rdata[1], req_ready[1], rd0);
      end
    end
    finish_rsp(1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer; int lat;
    issue(1, 1'b1, 3'b010, 32'd16, 32'h12345678);
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_state: valid=%b ready=%b required 0/1", rsp_valid[1], req_ready[1]);
    end
    xact(1, 1'b0, 3'b010, 32'd16, 32'h0, rd, er, lat, erd, eer);
    n_tests++;
    if (er !== 1'b0 || rd !== erd) begin
      n_fail++;
      $display("FAIL reset_mid_mem: err=%b rdata=%h required 0/%h", er, rd, erd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd; logic er, eer; int lat;
    int d; bit we; logic [2:0] f3; logic [31:0] a;
    for (int i = 0; i < 200; i++) begin
      d  = $urandom_range(0, 1);
      we = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom_range(0, 4*DEPTH + 15);
      xact(d, we, f3, a, $urandom, rd, er, lat, erd, eer);
      n_tests++;
      if (rd !== erd || er !== eer || lat != exp_lat(d)) begin
        n_fail++;
        $display("FAIL rand%0d dut%0d we=%b f3=%0d a=%0d: rdata=%h err=%b lat=%0d required %h/%b/%0d",
                 i, d, we, f3, a, rd, er, lat, erd, eer, exp_lat(d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_roundtrip();
    test_byte_merge();
    test_misalign();
    test_errors();
    test_wait_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
